// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: DATA_W data bits, optional parity, 1/2 stop bits,
// glitch-filtered start, break detect. Define UART_RX_MAJORITY_EN for 2-of-3 bit sampling.
module uart_rx_cfg #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16,
  parameter int OVS    = 16
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              rx,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_par_en,
  input  logic              cfg_par_odd,
  input  logic              cfg_stop2,
  output logic              rx_busy,
  output logic              rx_end,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_perr,
  output logic              rx_ferr,
  output logic              rx_break
);

  localparam int SW = $clog2(OVS);
  localparam int BW = 4;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC_AT = OVS/2 + 1;
`else
  localparam int DEC_AT = OVS/2;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t             state, state_n;
  logic               rx_q1, rxs;
  logic [DIV_W-1:0]   tick_cnt, div_live_m1, sh_div;
  logic               sh_par_en, sh_par_odd, sh_stop2;
  logic [SW-1:0]      s_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [DATA_W-1:0]  data_sh;
  logic               par_bit, s1_bit, stop_idx;
  logic               tick, dec, bit_val, done;
  logic               s1_now, ferr_n, perr_n, brk_n;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rx_q1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rxs   <= rx_q1;
    end
  end

  assign div_live_m1 = (cfg_div == '0) ? '0 : cfg_div - DIV_W'(1);
  assign tick        = (state != IDLE) && (tick_cnt == '0);
  assign dec         = tick && (s_cnt == SW'(DEC_AT));
  assign rx_busy     = (state != IDLE);

`ifdef UART_RX_MAJORITY_EN
  logic m0, m1;
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      m0 <= 1'b1;
      m1 <= 1'b1;
    end else if (tick) begin
      if (s_cnt == SW'(OVS/2 - 1)) m0 <= rxs;
      if (s_cnt == SW'(OVS/2))     m1 <= rxs;
    end
  end
  assign bit_val = (m0 & m1) | (m0 & rxs) | (m1 & rxs);
`else
  assign bit_val = rxs;
`endif

  // With stop2 the final decision lands on the second stop bit; s1 was stored earlier.
  assign s1_now = stop_idx ? s1_bit : bit_val;
  assign ferr_n = ~s1_now | (sh_stop2 & stop_idx & ~bit_val);
  assign perr_n = sh_par_en & (^data_sh ^ par_bit ^ sh_par_odd);
  assign brk_n  = (data_sh == '0) && !(sh_par_en && par_bit) && !s1_now;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    unique case (state)
      IDLE:   if (!rxs) state_n = START;
      START:  if (dec) state_n = bit_val ? IDLE : DATA;
      DATA:   if (dec && bit_cnt == BW'(DATA_W-1)) state_n = sh_par_en ? PARITY : STOP;
      PARITY: if (dec) state_n = STOP;
      STOP: begin
        if (dec && !(sh_stop2 && !stop_idx)) begin
          done    = 1'b1;
          state_n = brk_n ? BRK : IDLE;
        end
      end
      BRK:    if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      tick_cnt   <= '0;
      sh_div     <= '0;
      sh_par_en  <= 1'b0;
      sh_par_odd <= 1'b0;
      sh_stop2   <= 1'b0;
      s_cnt      <= '0;
      bit_cnt    <= '0;
      data_sh    <= '0;
      par_bit    <= 1'b0;
      s1_bit     <= 1'b0;
      stop_idx   <= 1'b0;
      rx_end     <= 1'b0;
      rx_data    <= '0;
      rx_perr    <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_break   <= 1'b0;
    end else begin
      rx_end <= done;
      if (done) begin
        rx_data  <= data_sh;
        rx_perr  <= perr_n;
        rx_ferr  <= ferr_n;
        rx_break <= brk_n;
      end
      // Divisor tracks the live config while idle, then runs from the frame shadow.
      if (state == IDLE)        tick_cnt <= div_live_m1;
      else if (tick_cnt == '0)  tick_cnt <= sh_div;
      else                      tick_cnt <= tick_cnt - DIV_W'(1);
      if (state == IDLE && !rxs) begin
        sh_div     <= div_live_m1;
        sh_par_en  <= cfg_par_en;
        sh_par_odd <= cfg_par_odd;
        sh_stop2   <= cfg_stop2;
      end
      if (state == IDLE)  s_cnt <= '0;
      else if (tick)      s_cnt <= (s_cnt == SW'(OVS-1)) ? '0 : s_cnt + SW'(1);
      if (state == START) bit_cnt <= '0;
      else if (state == DATA && dec) begin
        bit_cnt <= bit_cnt + BW'(1);
        data_sh <= {bit_val, data_sh[DATA_W-1:1]};
      end
      if (state == PARITY && dec) par_bit <= bit_val;
      if (state != STOP) stop_idx <= 1'b0;
      else if (dec) begin
        stop_idx <= 1'b1;
        if (!stop_idx) s1_bit <= bit_val;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8-bit and 7-bit instances share rx/config/reset;
// cfg_div=4, OVS=16 gives 64 clk per bit.
module tb_uart_rx_cfg;
  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic       rx = 1'b1;
  logic [15:0] cfg_div = 16'd4;
  logic       par_en = 1'b0, par_odd = 1'b0, stop2 = 1'b0;

  logic       busy8, end8, perr8, ferr8, brk8;
  logic [7:0] data8;
  logic       busy7, end7, perr7, ferr7, brk7;
  logic [6:0] data7;

  int errors = 0, checks = 0;
  int ends8 = 0, ends7 = 0;
  logic prev_end8 = 1'b0, busy_after8 = 1'b1;
  int n0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DATA_W(8), .DIV_W(16), .OVS(16)) u_dut (
    .clk(clk), .reset_(reset_), .rx(rx), .cfg_div(cfg_div),
    .cfg_par_en(par_en), .cfg_par_odd(par_odd), .cfg_stop2(stop2),
    .rx_busy(busy8), .rx_end(end8), .rx_data(data8),
    .rx_perr(perr8), .rx_ferr(ferr8), .rx_break(brk8));

  uart_rx_cfg #(.DATA_W(7), .DIV_W(16), .OVS(16)) u_dut7 (
    .clk(clk), .reset_(reset_), .rx(rx), .cfg_div(cfg_div),
    .cfg_par_en(par_en), .cfg_par_odd(par_odd), .cfg_stop2(stop2),
    .rx_busy(busy7), .rx_end(end7), .rx_data(data7),
    .rx_perr(perr7), .rx_ferr(ferr7), .rx_break(brk7));

  always @(negedge clk) begin
    if (prev_end8) busy_after8 = busy8;
    prev_end8 = end8;
    if (end8) ends8++;
    if (end7) ends7++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Mid-bit sampling sees the value driven 36 clk into the bit; a spike over 34..37 hits only that sample.
  task automatic drive_bit(input logic b, input bit spk);
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      rx = (spk && c >= 34 && c < 38) ? ~b : b;
    end
  endtask

  task automatic send(input int nb, input logic [8:0] d, input logic pb, input logic s2, input int spike_bit);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i], spike_bit == i + 1);
    if (par_en) drive_bit(pb, 1'b0);
    drive_bit(1'b1, 1'b0);
    if (stop2) drive_bit(s2, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_end", end8, 0);
    check("rst_data", data8, 0);
    check("rst_perr", perr8, 0);
    check("rst_ferr", ferr8, 0);
    check("rst_break", brk8, 0);
    reset_ = 1'b1;
    repeat (10) @(negedge clk);

    n0 = ends8;
    send(8, 9'h0A5, 1'b0, 1'b1, 0);
    check("a5_ends", ends8 - n0, 1);
    check("a5_data", data8, 8'hA5);
    check("a5_perr", perr8, 0);
    check("a5_ferr", ferr8, 0);
    check("a5_break", brk8, 0);
    check("a5_busy_after", busy_after8, 0);

    n0 = ends8;
    @(negedge clk) rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (24) @(negedge clk);
    check("glitch_busy", busy8, 0);
    check("glitch_ends", ends8 - n0, 0);
    send(8, 9'h03C, 1'b0, 1'b1, 0);
    check("3c_data", data8, 8'h3C);
    check("3c_ends", ends8 - n0, 1);

    par_en = 1'b1; par_odd = 1'b0;
    send(8, 9'h003, 1'b1, 1'b1, 0);
    check("par1_data", data8, 8'h03);
    check("par1_perr", perr8, 1);
    send(8, 9'h003, 1'b0, 1'b1, 0);
    check("par0_perr", perr8, 0);
    check("par0_ferr", ferr8, 0);
    par_en = 1'b0;

    stop2 = 1'b1;
    n0 = ends8;
    send(8, 9'h055, 1'b0, 1'b0, 0);
    check("st2_bad_ferr", ferr8, 1);
    check("st2_bad_data", data8, 8'h55);
    send(8, 9'h055, 1'b0, 1'b1, 0);
    check("st2_ok_ferr", ferr8, 0);
    check("st2_ends", ends8 - n0, 2);
    stop2 = 1'b0;

    n0 = ends8;
    @(negedge clk) rx = 1'b0;
    repeat (768) @(negedge clk);
    check("brk_busy_low", busy8, 1);
    check("brk_ends", ends8 - n0, 1);
    check("brk_data", data8, 0);
    check("brk_ferr", ferr8, 1);
    check("brk_break", brk8, 1);
    check("brk_perr", perr8, 0);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("brk_busy_high", busy8, 0);
    check("brk_ends_after", ends8 - n0, 1);
    repeat (64) @(negedge clk);

`ifdef UART_RX_MAJORITY_EN
    send(8, 9'h05A, 1'b0, 1'b1, 4);
    check("maj_spike_data", data8, 8'h5A);
    check("maj_spike_ferr", ferr8, 0);
`endif

    reset_ = 1'b0;
    repeat (3) @(negedge clk);
    reset_ = 1'b1;
    repeat (64) @(negedge clk);
    n0 = ends7;
    send(7, 9'h041, 1'b0, 1'b1, 0);
    check("w7_data", data7, 7'h41);
    check("w7_ends", ends7 - n0, 1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    reset_ = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("w7_rst_busy", busy7, 0);
    check("w7_rst_end", end7, 0);
    check("w7_rst_data", data7, 0);
    check("w7_rst_flags", {perr7, ferr7, brk7}, 0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    reset_ = 1'b1;
    repeat (128) @(negedge clk);
    check("w7_abort_ends", ends7 - n0, 1);
    send(7, 9'h041, 1'b0, 1'b1, 0);
    check("w7_again_data", data7, 7'h41);
    check("w7_again_ends", ends7 - n0, 2);
    check("w7_again_ferr", ferr7, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
